datapath_param: RTL and testbench

Parametrised next-generation datapath for the bus-based CPU: A/B registers, IR, PC, MAR, RAM, add/sub ALU with latched flags, and a shared bus driven by one of eight sources. Compared with the fixed 8-bit/4-bit-address datapath, it generalises data and address widths. It adds valid/ready handshakes on the input and output ports, a MAR auto-increment, and a global STALL that freezes all state while a handshake is pending. It sits under the microcode sequencer, which drives all control strobes.

---
 rtl/datapath_pkg.sv | 26 ++
 rtl/stream_port.sv | 42 ++++
 rtl/datapath_param.sv | 180 ++++++++++++++++++
 tb/tb_datapath_param.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for datapath_param: bus-source indices, stream-port
// direction and the width-consistency check used at elaboration.
package datapath_pkg;

  localparam int unsigned SRC_DEBUG = 0;
  localparam int unsigned SRC_A     = 1;
  localparam int unsigned SRC_B     = 2;
  localparam int unsigned SRC_IR    = 3;
  localparam int unsigned SRC_PC    = 4;
  localparam int unsigned SRC_ALU   = 5;
  localparam int unsigned SRC_RAM   = 6;
  localparam int unsigned SRC_IN    = 7;
  localparam int unsigned N_SRC     = 8;

  typedef enum logic {
    PORT_IN,
    PORT_OUT
  } port_dir_e;

  function automatic bit widths_ok(input int unsigned data_w,
                                   input int unsigned addr_w,
                                   input int unsigned opcode_w);
    return (data_w >= 4) && (opcode_w < data_w) && (addr_w <= data_w - opcode_w);
  endfunction

endpackage

// File: rtl/stream_port.sv
// One-entry handshake buffer: full flag plus data register.
// PORT_IN accepts a push only while empty; PORT_OUT lets a push overwrite.
module stream_port
  import datapath_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter port_dir_e   DIR = PORT_IN
) (
  input  logic         clk,
  input  logic         i_clear,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic [W-1:0] o_data
);

  logic         r_full;
  logic [W-1:0] r_data;
  logic         w_accept;

  always_comb begin
    w_accept = (DIR == PORT_IN) ? (i_push && !r_full) : i_push;
  end

  // A push wins over a pop so a simultaneous load keeps the entry valid.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/datapath_param.sv
// Parametrised bus-based CPU datapath with handshaked I/O and global STALL.
// Define DATAPATH_BUS_CHECK_EN to zero the bus and flag BUS_ERR on multiple drivers.
module datapath_param
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned OPCODE_W = 4
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                CLR,
  input  logic                CE,
  input  logic                Jn,
  input  logic                AIn,
  input  logic                BIn,
  input  logic                IIn,
  input  logic                OIn,
  input  logic                FIn,
  input  logic                MIn,
  input  logic                MINC,
  input  logic                RI,
  input  logic                SU,
  input  logic                DOn,
  input  logic                AOn,
  input  logic                BOn,
  input  logic                IOn,
  input  logic                COn,
  input  logic                EOn,
  input  logic                ROn,
  input  logic                NOn,
  input  logic [DATA_W-1:0]   DEBUG,
  input  logic [DATA_W-1:0]   IN_DATA,
  input  logic                IN_VALID,
  output logic                IN_READY,
  output logic [DATA_W-1:0]   OUT_DATA,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [DATA_W-1:0]   BUS,
  output logic [OPCODE_W-1:0] OPCODE,
  output logic                CF,
  output logic                ZF,
  output logic                STALL,
  output logic                BUS_ERR
);

  if (!widths_ok(DATA_W, ADDR_W, OPCODE_W)) begin : g_bad_widths
    $error("datapath_param: require DATA_W >= 4 and ADDR_W <= DATA_W - OPCODE_W");
  end

  logic [DATA_W-1:0] r_a, r_b, r_ir;
  logic [ADDR_W-1:0] r_pc, r_mar;
  logic              r_cf, r_zf;
  logic [DATA_W-1:0] r_ram [2**ADDR_W];

  logic              w_clear, w_stall, w_pop, w_out_load, w_out_drain;
  logic              w_in_full, w_out_full;
  logic [DATA_W-1:0] w_in_data, w_out_data, w_bus;
  logic [DATA_W:0]   w_alu;
  logic [N_SRC-1:0]  w_en;
  logic [DATA_W-1:0] w_src [N_SRC];

  assign w_clear = !RESETn || CLR;
  assign w_alu   = {1'b0, r_a} + {1'b0, (SU ? ~r_b : r_b)} + {{DATA_W{1'b0}}, SU};

  always_comb begin
    w_en            = '0;
    w_en[SRC_DEBUG] = !DOn;
    w_en[SRC_A]     = !AOn;
    w_en[SRC_B]     = !BOn;
    w_en[SRC_IR]    = !IOn;
    w_en[SRC_PC]    = !COn;
    w_en[SRC_ALU]   = !EOn;
    w_en[SRC_RAM]   = !ROn;
    w_en[SRC_IN]    = !NOn;
    w_src[SRC_DEBUG] = DEBUG;
    w_src[SRC_A]     = r_a;
    w_src[SRC_B]     = r_b;
    w_src[SRC_IR]    = {{OPCODE_W{1'b0}}, r_ir[DATA_W-OPCODE_W-1:0]};
    w_src[SRC_PC]    = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
    w_src[SRC_ALU]   = w_alu[DATA_W-1:0];
    w_src[SRC_RAM]   = r_ram[r_mar];
    w_src[SRC_IN]    = w_in_data;
  end

`ifdef DATAPATH_BUS_CHECK_EN
  logic w_multi;
  logic r_bus_err;

  always_comb begin
    w_bus   = '0;
    w_multi = ($countones(w_en) > 1);
    if (!w_multi) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (w_en[i]) w_bus = w_src[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_clear)      r_bus_err <= 1'b0;
    else if (w_multi) r_bus_err <= 1'b1;
  end

  assign BUS_ERR = r_bus_err;
`else
  // Scan from the lowest-priority source up so the first enable in order wins.
  always_comb begin
    w_bus = '0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (w_en[i-1]) w_bus = w_src[i-1];
    end
  end

  assign BUS_ERR = 1'b0;
`endif

  assign w_stall     = (!NOn && !w_in_full) || (OIn && w_out_full && !OUT_READY);
  assign w_pop       = !NOn && w_in_full && !w_stall;
  assign w_out_load  = OIn && !w_stall;
  assign w_out_drain = w_out_full && OUT_READY;

  stream_port #(.W(DATA_W), .DIR(PORT_IN)) u_in_port (
    .clk    (CLK),
    .i_clear(w_clear),
    .i_push (IN_VALID),
    .i_data (IN_DATA),
    .i_pop  (w_pop),
    .o_full (w_in_full),
    .o_data (w_in_data)
  );

  stream_port #(.W(DATA_W), .DIR(PORT_OUT)) u_out_port (
    .clk    (CLK),
    .i_clear(w_clear),
    .i_push (w_out_load),
    .i_data (w_bus),
    .i_pop  (w_out_drain),
    .o_full (w_out_full),
    .o_data (w_out_data)
  );

  always_ff @(posedge CLK) begin
    if (w_clear) begin
      r_a   <= '0;
      r_b   <= '0;
      r_ir  <= '0;
      r_pc  <= '0;
      r_mar <= '0;
      r_cf  <= 1'b0;
      r_zf  <= 1'b0;
    end else if (!w_stall) begin
      if (AIn) r_a  <= w_bus;
      if (BIn) r_b  <= w_bus;
      if (IIn) r_ir <= w_bus;
      if (FIn) begin
        r_cf <= w_alu[DATA_W];
        r_zf <= (w_alu[DATA_W-1:0] == '0);
      end
      if (!Jn)     r_pc <= w_bus[ADDR_W-1:0];
      else if (CE) r_pc <= r_pc + ADDR_W'(1);
      if (MIn)       r_mar <= w_bus[ADDR_W-1:0];
      else if (MINC) r_mar <= r_mar + ADDR_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!w_clear && !w_stall && RI) r_ram[r_mar] <= w_bus;
  end

  assign BUS       = w_bus;
  assign OPCODE    = r_ir[DATA_W-1 -: OPCODE_W];
  assign CF        = r_cf;
  assign ZF        = r_zf;
  assign STALL     = w_stall;
  assign IN_READY  = !w_in_full;
  assign OUT_VALID = w_out_full;
  assign OUT_DATA  = w_out_data;

endmodule

// File: tb/tb_datapath_param.sv
// Self-checking bench for datapath_param (8-bit data, 4-bit address/opcode):
// directed scenarios followed by randomized control sequences against a reference model.
module tb_datapath_param;

  logic       CLK = 1'b0;
  logic       RESETn, CLR, CE, Jn, AIn, BIn, IIn, OIn, FIn, MIn, MINC, RI, SU;
  logic       DOn, AOn, BOn, IOn, COn, EOn, ROn, NOn;
  logic [7:0] DEBUG, IN_DATA, OUT_DATA, BUS;
  logic       IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [3:0] OPCODE;
  logic       CF, ZF, STALL, BUS_ERR;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned m_a, m_b, m_ir, m_pc, m_mar, m_in_data, m_out_data;
  bit          m_cf, m_zf, m_in_full, m_out_valid, m_err;
  int unsigned m_ram [16];

  always #5 CLK = ~CLK;

  datapath_param #(.DATA_W(8), .ADDR_W(4), .OPCODE_W(4)) dut (
    .CLK(CLK), .RESETn(RESETn), .CLR(CLR), .CE(CE), .Jn(Jn), .AIn(AIn), .BIn(BIn),
    .IIn(IIn), .OIn(OIn), .FIn(FIn), .MIn(MIn), .MINC(MINC), .RI(RI), .SU(SU),
    .DOn(DOn), .AOn(AOn), .BOn(BOn), .IOn(IOn), .COn(COn), .EOn(EOn), .ROn(ROn), .NOn(NOn),
    .DEBUG(DEBUG), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .BUS(BUS), .OPCODE(OPCODE), .CF(CF), .ZF(ZF), .STALL(STALL), .BUS_ERR(BUS_ERR)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned alu_sum();
    return SU ? (m_a + 256 - m_b) : (m_a + m_b);
  endfunction

  function automatic int unsigned n_low();
    return 32'(!DOn) + 32'(!AOn) + 32'(!BOn) + 32'(!IOn) + 32'(!COn) + 32'(!EOn) + 32'(!ROn) + 32'(!NOn);
  endfunction

  function automatic int unsigned exp_bus();
    bit          en  [8];
    int unsigned src [8];
    int unsigned r = 0;
    en  = '{!DOn, !AOn, !BOn, !IOn, !COn, !EOn, !ROn, !NOn};
    src = '{32'(DEBUG), m_a, m_b, m_ir % 16, m_pc, alu_sum() % 256, m_ram[m_mar], m_in_data};
    for (int i = 7; i >= 0; i--) if (en[i]) r = src[i];
`ifdef DATAPATH_BUS_CHECK_EN
    if (n_low() > 1) r = 0;
`endif
    return r;
  endfunction

  function automatic bit exp_stall();
    return (!NOn && !m_in_full) || (OIn && m_out_valid && !OUT_READY);
  endfunction

  task automatic model_tick();
    int unsigned b  = exp_bus();
    int unsigned s  = alu_sum();
    bit          st = exp_stall();
    bit          nf = m_in_full;
    int unsigned nd = m_in_data;
    if (!RESETn || CLR) begin
      m_a = 0; m_b = 0; m_ir = 0; m_pc = 0; m_mar = 0; m_cf = 0; m_zf = 0;
      m_in_full = 0; m_in_data = 0; m_out_valid = 0; m_out_data = 0; m_err = 0;
      return;
    end
`ifdef DATAPATH_BUS_CHECK_EN
    if (n_low() > 1) m_err = 1;
`endif
    if (IN_VALID && !m_in_full) begin nf = 1; nd = 32'(IN_DATA); end
    if (!st) begin
      if (RI)  m_ram[m_mar] = b;
      if (FIn) begin m_cf = (s >= 256); m_zf = (s % 256 == 0); end
      if (AIn) m_a  = b;
      if (BIn) m_b  = b;
      if (IIn) m_ir = b;
      if (!Jn) m_pc = b % 16; else if (CE) m_pc = (m_pc + 1) % 16;
      if (MIn) m_mar = b % 16; else if (MINC) m_mar = (m_mar + 1) % 16;
      if (!NOn && m_in_full) nf = 0;
      if (OIn) begin m_out_valid = 1; m_out_data = b; end
      else if (m_out_valid && OUT_READY) m_out_valid = 0;
    end else if (m_out_valid && OUT_READY) begin
      m_out_valid = 0;
    end
    m_in_full = nf;
    m_in_data = nd;
  endtask

  // Compare every visible output mid-cycle, advance the model, then cross the edge.
  task automatic step();
    @(negedge CLK);
    check("bus",       32'(BUS),       exp_bus());
    check("stall",     32'(STALL),     32'(exp_stall()));
    check("in_ready",  32'(IN_READY),  32'(!m_in_full));
    check("out_valid", 32'(OUT_VALID), 32'(m_out_valid));
    check("out_data",  32'(OUT_DATA),  m_out_data);
    check("cf",        32'(CF),        32'(m_cf));
    check("zf",        32'(ZF),        32'(m_zf));
    check("opcode",    32'(OPCODE),    m_ir / 16);
    check("bus_err",   32'(BUS_ERR),   32'(m_err));
    model_tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RESETn = 1; CLR = 0; CE = 0; Jn = 1; AIn = 0; BIn = 0; IIn = 0; OIn = 0; FIn = 0;
    MIn = 0; MINC = 0; RI = 0; SU = 0;
    DOn = 1; AOn = 1; BOn = 1; IOn = 1; COn = 1; EOn = 1; ROn = 1; NOn = 1;
    IN_VALID = 0; OUT_READY = 0;
  endtask

  task automatic set_src(input int unsigned k);
    case (k)
      0: DOn = 0; 1: AOn = 0; 2: BOn = 0; 3: IOn = 0;
      4: COn = 0; 5: EOn = 0; 6: ROn = 0; default: NOn = 0;
    endcase
  endtask

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    idle(); DOn = 0; DEBUG = a; AIn = 1; step();
    idle(); DOn = 0; DEBUG = b; BIn = 1; step();
  endtask

  initial begin
    DEBUG = 0; IN_DATA = 0;
    m_ram = '{default: 0};
    idle(); RESETn = 0; step(); step();

    idle(); AOn = 0; #1 check("rst_bus_a", 32'(BUS), 0); step();
    idle(); BOn = 0; #1 check("rst_bus_b", 32'(BUS), 0); step();
    idle(); COn = 0; #1 check("rst_bus_pc", 32'(BUS), 0);
    check("rst_in_ready", 32'(IN_READY), 1);
    check("rst_out_valid", 32'(OUT_VALID), 0);
    step();

    for (int i = 0; i < 16; i++) begin
      idle(); DOn = 0; DEBUG = 8'($urandom); RI = 1; MINC = 1; step();
    end

    load_ab(8'hFF, 8'h01);
    idle(); FIn = 1; EOn = 0; #1 check("add_res", 32'(BUS), 0); step();
    idle(); #1 check("add_cf", 32'(CF), 1); check("add_zf", 32'(ZF), 1);
    load_ab(8'h05, 8'h05);
    idle(); FIn = 1; SU = 1; step();
    idle(); #1 check("sub_eq_cf", 32'(CF), 1); check("sub_eq_zf", 32'(ZF), 1);
    load_ab(8'h03, 8'h05);
    idle(); FIn = 1; SU = 1; EOn = 0; #1 check("sub_res", 32'(BUS), 'hFE); step();
    idle(); #1 check("sub_cf", 32'(CF), 0); check("sub_zf", 32'(ZF), 0);

    for (int i = 0; i < 16; i++) begin idle(); CE = 1; step(); end
    idle(); COn = 0; #1 check("pc_wrap", 32'(BUS), 0); step();
    idle(); DOn = 0; DEBUG = 8'h0A; Jn = 0; CE = 1; step();
    idle(); COn = 0; #1 check("pc_jump", 32'(BUS), 'h0A); step();

    idle(); DOn = 0; DEBUG = 8'h0F; MIn = 1; step();
    idle(); DOn = 0; DEBUG = 8'h5A; RI = 1; step();
    idle(); MINC = 1; step();
    idle(); ROn = 0; #1 check("mar_wrap_rd", 32'(BUS), m_ram[0]); step();
    idle(); DOn = 0; DEBUG = 8'h0F; MIn = 1; step();
    idle(); ROn = 0; #1 check("ram_rd", 32'(BUS), 'h5A); step();

    idle(); NOn = 0; AIn = 1; #1 check("in_stall", 32'(STALL), 1); step();
    idle(); AOn = 0; #1 check("in_a_held", 32'(BUS), 'h03); step();
    idle(); IN_VALID = 1; IN_DATA = 8'h33; step();
    idle(); NOn = 0; AIn = 1; #1 check("in_unstall", 32'(STALL), 0);
    check("in_full", 32'(IN_READY), 0); step();
    idle(); AOn = 0; #1 check("in_a_load", 32'(BUS), 'h33);
    check("in_ready_after", 32'(IN_READY), 1); step();

    idle(); DOn = 0; DEBUG = 8'h11; OIn = 1; step();
    idle(); #1 check("out_v1", 32'(OUT_VALID), 1); check("out_d1", 32'(OUT_DATA), 'h11);
    DOn = 0; DEBUG = 8'h22; OIn = 1; #1 check("out_stall", 32'(STALL), 1); step();
    check("out_hold", 32'(OUT_DATA), 'h11);
    OUT_READY = 1; #1 check("out_unstall", 32'(STALL), 0); step();
    check("out_d2", 32'(OUT_DATA), 'h22); check("out_v2", 32'(OUT_VALID), 1);
    idle(); OUT_READY = 1; step();
    check("out_drained", 32'(OUT_VALID), 0);

`ifdef DATAPATH_BUS_CHECK_EN
    idle(); AOn = 0; BOn = 0; #1 check("multi_bus", 32'(BUS), 0); step();
    idle(); step();
    check("bus_err_sticky", 32'(BUS_ERR), 1);
`endif

    for (int n = 0; n < 3000; n++) begin
      idle();
      RESETn = ($urandom_range(199) != 0);
      CLR = ($urandom_range(199) == 0);
      CE = ($urandom_range(3) == 0); Jn = ($urandom_range(7) != 0);
      AIn = ($urandom_range(3) == 0); BIn = ($urandom_range(3) == 0);
      IIn = ($urandom_range(3) == 0); OIn = ($urandom_range(3) == 0);
      FIn = ($urandom_range(3) == 0); MIn = ($urandom_range(5) == 0);
      MINC = ($urandom_range(3) == 0); RI = ($urandom_range(3) == 0);
      SU = 1'($urandom_range(1));
      IN_VALID = 1'($urandom_range(1)); OUT_READY = 1'($urandom_range(1));
      IN_DATA = 8'($urandom); DEBUG = 8'($urandom);
      case ($urandom_range(9))
        8: begin set_src($urandom_range(7)); set_src($urandom_range(7)); end
        9: ;
        default: set_src($urandom_range(7));
      endcase
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
